ethernet_smi_frame_engine: RTL
==============================

# ethernet_smi_frame_engine

- Clause-22 MDIO management-frame engine for the Ethernet PHY.
- Sits directly downstream of the SMI clock divider and consumes its `finalCycle` pulse (one clk every 50 cycles at 100 MHz) as `smiTick`. Each tick is one MDC half-period, which gives a 1 MHz MDC.
- Serialises one 64-bit read or write frame per request, drives MDC/MDIO, and returns read data with a one-cycle `done` pulse.

## Interface
Parameters: none.

- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `smiTick` in 1: one-cycle pulse from the SMI clock unit; each pulse is one MDC half-period.
- `start` in 1: frame request; accepted only when `busy`=0.
- `opWrite` in 1: 1 = write frame, 0 = read frame.
- `phyAddr` in 5: PHY address.
- `regAddr` in 5: register address.
- `writeData` in 16: write payload.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse at frame end.
- `readData` out 16: data from the last read frame.
- `mdc` out 1: MDC pin.
- `mdioOut` out 1: MDIO output data.
- `mdioOutEnable` out 1: MDIO tristate enable; 1 = drive.
- `mdioIn` in 1: MDIO pin input; already synchronised externally.

## Operation
- **States:**
  - IDLE.
  - LOW: `mdc`=0, waiting for the rising tick.
  - HIGH: `mdc`=1, waiting for the falling tick.
- **Bit counter:** 6 bits, 0..63.
- **Acceptance:** in IDLE with `start`=1, on that clock edge:
  - `opWrite`, `phyAddr`, `regAddr` and `writeData` are captured into a 64-bit shift register.
  - `busy` goes to 1, bit counter to 0, state to LOW.
  - Later input changes are ignored.
- **Frame, MSB first, bit index 0..63:**
  - bits 0-31: preamble, all 1.
  - bits 32-33: ST = 01.
  - bits 34-35: OP = 01 for write, 10 for read.
  - bits 36-40: PHYAD.
  - bits 41-45: REGAD.
  - bits 46-47: TA.
  - bits 48-63: DATA.
- **TA and DATA on a write:** TA = 10; DATA = `writeData`.
- **`mdioOut`** = current shift-register MSB while busy, and 1 when idle.
- **`mdioOutEnable`:**
  - 1 for bits 0-45 on both frame types.
  - 1 for bits 46-63 on a write.
  - 0 for bits 46-63 on a read.
  - 0 in IDLE.
- **LOW + tick:** `mdc`←1, state←HIGH. On a read with bit index 48..63, `readData` ← {`readData`[14:0], `mdioIn`}.
- **HIGH + tick, index <63:** `mdc`←0, shift register shifts left, index increments, state←LOW.
- **HIGH + tick, index =63:** `mdc`←0, state←IDLE, `busy`←0, `done`←1 for one cycle, `mdioOutEnable`←0, `mdioOut`←1.
- **`smiTick` in IDLE** is ignored. A tick in the acceptance cycle does not count; bit 0 rises on the next tick after acceptance.
- **`readData`:**
  - Written only by read frames.
  - Holds its value across write frames.
  - Valid from `done` until the next read frame starts shifting.
- **Reset:** valid at any time, including mid-frame.
  - Returns immediately to IDLE with `mdc`=0, `mdioOut`=1, `mdioOutEnable`=0, `busy`=0, `done`=0, `readData`=16'h0000.
  - No `done` is produced for an aborted frame.

## Timing
- All outputs are registered and change only on `clk` edges, or asynchronously on `reset`.
- `busy` is high from the cycle after acceptance.
- Frame length is exactly 128 ticks after acceptance. With a 50-cycle tick that is ≈6400 clk, about 64 µs.
- `done` is high for exactly the one cycle after the edge of the 128th tick. `busy` falls in that same cycle.
- `start` with `busy`=1 is dropped, with no queuing.
- `start` during the `done` cycle is accepted, so back-to-back frames are allowed.
- **MDIO timing:**
  - MDIO output changes only on falling-tick edges or at acceptance, so the PHY sees ≥50 clk of setup and hold around each MDC rise.
  - `mdioIn` is sampled on the rising-tick edge, i.e. the value the PHY drove after the previous MDC rise.

## Test plan
- **Reset:** assert `reset` → `mdc`=0, `mdioOut`=1, `mdioOutEnable`=0, `busy`=0, `done`=0, `readData`=0.
- **Write frame:** write with `phyAddr`=5'h01, `regAddr`=5'h00, `writeData`=16'h1200, and sample `mdioOut` on each `mdc` rise.
  - Expect 32×1, then 01 01 00001 00000 10 0001001000000000.
  - Expect `mdioOutEnable`=1 for all 64 bits.
  - Expect `done` exactly once, one cycle after the 128th tick.
- **Read frame:** read with `phyAddr`=5'h1F, `regAddr`=5'h02; a PHY model drives 16'h0141 MSB first after each MDC rise from bit 47.
  - Expect OP=10.
  - Expect `mdioOutEnable`=0 for bits 46-63.
  - Expect `readData`=16'h0141 at `done`.
  - A following write leaves `readData`=16'h0141.
- **Handshake:** pulse `start` mid-frame → it is ignored and the frame is unchanged. Raise `start` in the `done` cycle → the second frame begins and `busy` is 1 on the next cycle.
- **Tick alignment:** `smiTick` coincident with `start` in IDLE → `mdc` stays 0 until the next tick. Vary the tick period (50, then 3) → bit sequence and 128-tick length are identical.
- **Reset mid-frame:** assert `reset` at bit 20 → outputs return to reset values immediately and there is no `done`. The next write frame is bit-exact.

Source files
------------

// File: rtl/ethernet_smi_frame_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ethernet_smi_frame_engine
//
// Clause-22 MDIO management-frame engine. Serialises one 64-bit read or write
// frame per request onto MDC/MDIO, pacing every MDC half-period from the
// smiTick pulse of the SMI clock divider, and returns read data with a
// one-cycle done pulse.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   smiTick        in   one-cycle pulse, one per MDC half-period
//   start          in   frame request, accepted only while idle
//   opWrite        in   1 = write frame, 0 = read frame
//   phyAddr[4:0]   in   PHY address
//   regAddr[4:0]   in   register address
//   writeData[15:0] in  write payload
//   busy           out  high while a frame is in progress
//   done           out  one-cycle pulse at frame end
//   readData[15:0] out  data from the last read frame
//   mdc            out  MDC pin
//   mdioOut        out  MDIO output data
//   mdioOutEnable  out  MDIO tristate enable, 1 = drive
//   mdioIn         in   MDIO pin input, already synchronised
// ---------------------------------------------------------------------------
module ethernet_smi_frame_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        smiTick,
    input  logic        start,
    input  logic        opWrite,
    input  logic [4:0]  phyAddr,
    input  logic [4:0]  regAddr,
    input  logic [15:0] writeData,
    output logic        busy,
    output logic        done,
    output logic [15:0] readData,
    output logic        mdc,
    output logic        mdioOut,
    output logic        mdioOutEnable,
    input  logic        mdioIn
);

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_LOW  = 2'd1;  // mdc low, waiting for rising tick
    localparam logic [1:0] STATE_HIGH = 2'd2;  // mdc high, waiting for falling tick

    localparam logic [5:0] TA_FIRST_BIT   = 6'd46;
    localparam logic [5:0] DATA_FIRST_BIT = 6'd48;
    localparam logic [5:0] LAST_BIT       = 6'd63;

    logic [1:0]  state;
    logic [5:0]  bitIndex;
    logic [63:0] shiftReg;
    logic        isWrite;

    logic [63:0] frameWord;
    logic [5:0]  nextIndex;

    // Preamble, ST, OP, PHYAD, REGAD, then TA+DATA. On a read the last 18 bits
    // are never driven (enable is low), so they are simply filled with ones.
    assign frameWord = {32'hFFFF_FFFF, 2'b01, (opWrite ? 2'b01 : 2'b10), phyAddr, regAddr,
                        (opWrite ? {2'b10, writeData} : 18'h3FFFF)};

    assign nextIndex = bitIndex + 6'd1;

    // The shift register MSB is the MDIO output flop. Idle and post-frame it
    // holds all ones, so mdioOut reads 1 whenever nothing is being sent.
    assign mdioOut = shiftReg[63];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would make ordering significant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= STATE_IDLE;
            bitIndex      <= 6'd0;
            // NOTE: the datapath registers are reset too, because the shift
            // register directly drives the MDIO pin and must idle at 1.
            shiftReg      <= '1;
            isWrite       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            readData      <= 16'h0000;
            mdc           <= 1'b0;
            mdioOutEnable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    // A tick in the acceptance cycle is deliberately ignored.
                    if (start) begin
                        shiftReg      <= frameWord;
                        isWrite       <= opWrite;
                        bitIndex      <= 6'd0;
                        busy          <= 1'b1;
                        mdioOutEnable <= 1'b1;
                        state         <= STATE_LOW;
                    end
                end
                STATE_LOW: begin
                    if (smiTick) begin
                        mdc   <= 1'b1;
                        state <= STATE_HIGH;
                        // The PHY drove this bit after the previous MDC rise.
                        if (!isWrite && bitIndex >= DATA_FIRST_BIT) begin
                            readData <= {readData[14:0], mdioIn};
                        end
                    end
                end
                STATE_HIGH: begin
                    if (smiTick) begin
                        mdc <= 1'b0;
                        if (bitIndex == LAST_BIT) begin
                            state         <= STATE_IDLE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            mdioOutEnable <= 1'b0;
                            shiftReg      <= '1;
                        end else begin
                            shiftReg      <= {shiftReg[62:0], 1'b1};
                            bitIndex      <= nextIndex;
                            // Release the bus from the turnaround onwards on a read.
                            mdioOutEnable <= isWrite || (nextIndex < TA_FIRST_BIT);
                            state         <= STATE_LOW;
                        end
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule
